// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO interconnect: FSM encoding, default peripheral
// tags and the error read pattern.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] TAG_RAM     = 4'h0;
  localparam logic [3:0] TAG_COUNTER = 4'h1;
  localparam logic [3:0] TAG_PITCH   = 4'h2;
  localparam logic [3:0] TAG_VRAM    = 4'hc;
  localparam logic [3:0] TAG_PS2     = 4'hd;
  localparam logic [3:0] TAG_GPIO    = 4'he;
  localparam logic [3:0] TAG_SW      = 4'hf;
  localparam logic [3:0] TAG_AUX     = 4'h3;

  // Slave 0 sits in the least significant nibble.
  localparam logic [31:0] DEFAULT_TAGS = {TAG_AUX, TAG_SW, TAG_GPIO, TAG_PS2,
                                          TAG_VRAM, TAG_PITCH, TAG_COUNTER, TAG_RAM};

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational region decode: compares an address tag against the slave tag
// table and returns a one-hot hit vector (lowest index wins) plus a miss flag.
module mmio_addr_decode #(
  parameter int N_SLAVES = 8,
  parameter int SEL_W    = 4,
  parameter logic [N_SLAVES*SEL_W-1:0] SLAVE_TAGS = mmio_pkg::DEFAULT_TAGS
) (
  input  logic [SEL_W-1:0]    tag,
  output logic [N_SLAVES-1:0] hit,
  output logic                miss
);

  logic found;

  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!found && (SLAVE_TAGS[i*SEL_W +: SEL_W] == tag)) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = !found;
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Registered MMIO interconnect between the CPU data port and N slaves with
// one-hot req/ack handshake, timeout and fault-address capture.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int N_SLAVES = 8,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SEL_W    = 4,
  parameter logic [N_SLAVES*SEL_W-1:0] SLAVE_TAGS = DEFAULT_TAGS,
  parameter int TIMEOUT  = 64,
  parameter logic [DATA_W-1:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_ready,
  output logic                       cpu_err,
  output logic [N_SLAVES-1:0]        slv_req,
  output logic                       slv_we,
  output logic [ADDR_W-SEL_W-1:0]    slv_addr,
  output logic [DATA_W-1:0]          slv_wdata,
  input  logic [N_SLAVES-1:0]        slv_ack,
  input  logic [N_SLAVES*DATA_W-1:0] slv_rdata,
  output logic [ADDR_W-1:0]          err_addr,
  output logic [7:0]                 err_count
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t                state, state_nx;
  logic [TMR_W-1:0]      timer;
  logic [ADDR_W-1:0]     addr_p0;
  logic [N_SLAVES-1:0]   hit;
  logic                  miss;
  logic                  ack_hit;
  logic                  expired;
  logic [DATA_W-1:0]     rdata_sel;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  mmio_addr_decode #(
    .N_SLAVES  (N_SLAVES),
    .SEL_W     (SEL_W),
    .SLAVE_TAGS(SLAVE_TAGS)
  ) u_decode (
    .tag (cpu_addr[ADDR_W-1 -: SEL_W]),
    .hit (hit),
    .miss(miss)
  );

  // slv_req doubles as the registered slave select during ACCESS.
  assign ack_hit  = |(slv_ack & slv_req);
  assign expired  = (timer == TMR_LAST);
  assign slv_addr = addr_p0[ADDR_W-SEL_W-1:0];

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (slv_req[i]) rdata_sel = rdata_sel | slv_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (cpu_req) state_nx = miss ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (ack_hit || expired) state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Ack is checked before expiry so a same-cycle ack completes cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      slv_req   <= '0;
      slv_we    <= 1'b0;
      slv_wdata <= '0;
      addr_p0   <= '0;
      err_addr  <= '0;
      err_count <= '0;
      timer     <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            slv_we    <= cpu_we;
            slv_wdata <= cpu_wdata;
            addr_p0   <= cpu_addr;
            timer     <= '0;
            if (miss) begin
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= ERR_RDATA;
              err_addr  <= cpu_addr;
              err_count <= sat_inc(err_count);
            end else begin
              slv_req <= hit;
            end
          end
        end
        ST_ACCESS: begin
          if (ack_hit) begin
            slv_req   <= '0;
            cpu_ready <= 1'b1;
            cpu_rdata <= slv_we ? '0 : rdata_sel;
          end else if (expired) begin
            slv_req   <= '0;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= ERR_RDATA;
            err_addr  <= addr_p0;
            err_count <= sat_inc(err_count);
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Randomized self-checking bench for mmio_bus_ctrl with a transaction-level
// reference model and a behavioural slave responder.
module tb_mmio_bus_ctrl;

  localparam int N       = 8;
  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int SW      = 4;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cpu_req;
  logic            cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic [DW-1:0]   cpu_rdata;
  logic            cpu_ready;
  logic            cpu_err;
  logic [N-1:0]    slv_req;
  logic            slv_we;
  logic [AW-SW-1:0] slv_addr;
  logic [DW-1:0]   slv_wdata;
  logic [N-1:0]    slv_ack;
  logic [N*DW-1:0] slv_rdata;
  logic [AW-1:0]   err_addr;
  logic [7:0]      err_count;

  mmio_bus_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .cpu_err  (cpu_err),
    .slv_req  (slv_req),
    .slv_we   (slv_we),
    .slv_addr (slv_addr),
    .slv_wdata(slv_wdata),
    .slv_ack  (slv_ack),
    .slv_rdata(slv_rdata),
    .err_addr (err_addr),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0]  tags [N] = '{4'h0, 4'h1, 4'h2, 4'hc, 4'hd, 4'he, 4'hf, 4'h3};
  logic [31:0] m_err_addr  = '0;
  int          m_err_count = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // One CPU access; the bench acts as the slave and acks after d request cycles.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int d, input bit spur);
    int          tgt, req_cyc, cyc, exp_req_cyc;
    bit          done, exp_err;
    logic [N-1:0] exp_req;
    logic [31:0] exp_rd;
    tgt = -1;
    for (int i = 0; i < N; i++) if (tgt < 0 && tags[i] == addr[31:28]) tgt = i;
    exp_req = (tgt >= 0) ? N'(1 << tgt) : '0;
    for (int i = 0; i < N; i++) slv_rdata[i*DW +: DW] = $urandom;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; slv_ack = '0;
    req_cyc = 0; cyc = 0; done = 0;
    while (!done && cyc < TIMEOUT + 20) begin
      @(posedge clk); #1;
      cyc++;
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      slv_ack   = '0;
      if (cpu_ready) begin
        done = 1;
      end else if (slv_req != '0) begin
        req_cyc++;
        chk("slv_req", slv_req, exp_req);
        chk("slv_we", slv_we, we);
        chk("slv_addr", slv_addr, addr[AW-SW-1:0]);
        chk("slv_wdata", slv_wdata, wdata);
        if (tgt >= 0 && req_cyc - 1 == d) slv_ack[tgt] = 1'b1;
        if (spur) slv_ack = slv_ack | (N'($urandom) & ~exp_req);
      end
    end
    cpu_req = 1'b0;
    slv_ack = '0;
    chk("completed", done, 1'b1);
    if (tgt < 0) begin
      exp_err = 1; exp_req_cyc = 0;
    end else if (d < TIMEOUT) begin
      exp_err = 0; exp_req_cyc = d + 1;
    end else begin
      exp_err = 1; exp_req_cyc = TIMEOUT;
    end
    exp_rd = exp_err ? 32'hDEAD_BEEF : (we ? 32'h0 : slv_rdata[tgt*DW +: DW]);
    if (exp_err) begin
      m_err_addr = addr;
      if (m_err_count < 255) m_err_count++;
    end
    chk("cpu_err", cpu_err, exp_err);
    chk("cpu_rdata", cpu_rdata, exp_rd);
    chk("latency", cyc, exp_req_cyc + 1);
    chk("req_cycles", req_cyc, exp_req_cyc);
    chk("err_addr", err_addr, m_err_addr);
    chk("err_count", err_count, m_err_count);
    chk("req_dropped", slv_req, 0);
    @(posedge clk); #1;
    chk("ready_pulse", cpu_ready, 1'b0);
  endtask

  initial begin
    int r, d;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    slv_ack = '0; slv_rdata = '0;
    #2;
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_req", slv_req, 0);
    chk("rst_we", slv_we, 0);
    chk("rst_addr", slv_addr, 0);
    chk("rst_wdata", slv_wdata, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_count", err_count, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);
    do_txn(1'b1, 32'hE000_0000, 32'h0000_00A5, 5, 1'b0);
    do_txn(1'b0, 32'h7000_0000, 32'h0, 0, 1'b0);
    do_txn(1'b0, 32'hC000_0100, 32'h0, 1000, 1'b0);
    do_txn(1'b1, 32'h1000_0008, 32'h1234, 1000, 1'b0);
    do_txn(1'b0, 32'hD000_0004, 32'h0, TIMEOUT - 1, 1'b1);
    do_txn(1'b0, 32'h3000_0020, 32'h0, 2, 1'b1);

    // Reset in the middle of an access.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000_0004; slv_ack = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_req_before", slv_req, 8'b0000_0010);
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_req", slv_req, 0);
    chk("abort_ready", cpu_ready, 0);
    chk("abort_rdata", cpu_rdata, 0);
    chk("abort_err_addr", err_addr, 0);
    chk("abort_err_count", err_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_err_addr = '0; m_err_count = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_abort_ready", cpu_ready, 0);
      chk("post_abort_req", slv_req, 0);
    end
    do_txn(1'b0, 32'h2000_0040, 32'h0, 1, 1'b0);

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       d = $urandom_range(0, 6);
      else if (r == 7) d = TIMEOUT - 1;
      else if (r == 8) d = TIMEOUT + 10;
      else             d = 0;
      do_txn(1'($urandom), $urandom, $urandom, d, 1'($urandom));
    end

    // Drive the error counter into saturation with unmapped accesses.
    for (int k = 0; k < 260; k++)
      do_txn(1'($urandom), {4'h4 + 4'($urandom_range(0, 7)), 28'($urandom)}, $urandom, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
Parametrised, registered memory-mapped I/O interconnect between the single-issue CPU data port and N peripheral slaves (RAM, counter, pitch generator, VRAM, PS/2, GPIO, switches, ...).
- Decodes the top SEL_W address bits against a per-slave tag table.
- Drives a one-hot request/acknowledge handshake so slow slaves can insert wait states.
- Returns read data and a bus-error flag for unmapped addresses or timed-out slaves.
- Latches the faulting address for software diagnosis.

Parameters:
N_SLAVES, 8, number of slave ports (1..16).
DATA_W, 32, data width.
ADDR_W, 32, CPU address width.
SEL_W, 4, address bits [ADDR_W-1 -: SEL_W] used for decode.
SLAVE_TAGS, {4'h0,4'h1,4'h2,4'hc,4'hd,4'he,4'hf,4'h3}, packed N_SLAVES*SEL_W tag table; slave i owns tag SLAVE_TAGS[i*SEL_W +: SEL_W].
TIMEOUT, 64, max cycles waiting for slv_ack before error (>=2).
ERR_RDATA, 32'hDEAD_BEEF, read data returned on error.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  access request; held high until cpu_ready
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid when cpu_ready
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  error qualifier, valid with cpu_ready
slv_req  out  N_SLAVES  one-hot request
slv_we  out  1  shared write strobe qualifier
slv_addr  out  ADDR_W-SEL_W  shared offset within region (low bits of cpu_addr)
slv_wdata  out  DATA_W  shared write data
slv_ack  in  N_SLAVES  per-slave completion, one cycle
slv_rdata  in  N_SLAVES*DATA_W  flattened read data, slave i at [i*DATA_W +: DATA_W]
err_addr  out  ADDR_W  address of most recent failed access
err_count  out  8  saturating error counter

Behaviour:
- Reset values (async, rst_n low): state IDLE; all outputs 0 (cpu_rdata, cpu_ready, cpu_err, slv_req, slv_we, slv_addr, slv_wdata, err_addr, err_count); timer 0.
- FSM states:
  - IDLE: on cpu_req=1, register we/addr/wdata and decode.
    - Tag hit on slave i (lowest index wins on duplicate tags): next cycle slv_req[i]=1; go to ACCESS.
    - No hit: go to RESP with err.
  - ACCESS: slv_req[i], slv_we, slv_addr and slv_wdata are held stable; timer increments each cycle.
    - slv_ack[i]=1 (ack from other slaves ignored): capture slv_rdata slice i into cpu_rdata (writes capture 0); drop slv_req the following cycle; go to RESP.
    - Timer reaching TIMEOUT-1 without ack: drop slv_req; go to RESP with err.
  - RESP: cpu_ready=1 for exactly one cycle; cpu_err as flagged.
    - On err: cpu_rdata=ERR_RDATA, err_addr=registered addr, err_count+=1 (saturates at 255).
    - Return to IDLE; the next request may be accepted in the following cycle.
- Latency: request sampled at cycle 0 -> slv_req at cycle 1 -> ack at earliest cycle 1 -> cpu_ready at cycle 2. Minimum 3 cycles from req to ready (inclusive); unmapped access returns ready at cycle 1.
- cpu_req is ignored outside IDLE; changes to cpu_addr/cpu_wdata mid-access have no effect (registered copies are used).
- slv_ack arriving in the same cycle as the timeout: ack wins, no error.
- rst_n asserted mid-access aborts immediately: slv_req drops asynchronously and no cpu_ready is issued.
- Outputs are fully registered; there is no combinational path from cpu_* to slv_* or from slv_ack to cpu_ready.

Decomposition:
- Shared package mmio_pkg: state encoding (IDLE/ACCESS/RESP), default tag constants per peripheral (TAG_RAM=4'h0, TAG_COUNTER=4'h1, TAG_PITCH=4'h2, TAG_VRAM=4'hc, TAG_PS2=4'hd, TAG_GPIO=4'he, TAG_SW=4'hf), ERR_RDATA default.
- One sub-module, mmio_addr_decode: combinational tag compare producing one-hot hit vector plus miss flag, parametrised on N_SLAVES/SEL_W/SLAVE_TAGS.

Test Plan:
- Read slave 0 (addr 0x0000_0010) with slv_ack on the first ACCESS cycle, slv_rdata slice0=0x1234_5678 -> slv_req=8'b0000_0001 at cycle 1, cpu_ready at cycle 2, cpu_rdata=0x1234_5678, cpu_err=0.
- Write GPIO (addr 0xE000_0000, data 0xA5) with ack delayed 5 cycles -> slv_req[5], slv_we=1 and slv_wdata=0xA5 stable for 6 cycles, single cpu_ready pulse, cpu_err=0.
- Unmapped addr 0x7000_0000 -> no slv_req, cpu_ready at cycle 1, cpu_err=1, cpu_rdata=0xDEAD_BEEF, err_addr=0x7000_0000, err_count=1.
- Slave never acks (TIMEOUT=64) -> slv_req high exactly 64 cycles, then cpu_ready with cpu_err=1; second timeout -> err_count=2.
- Ack on the timeout cycle plus a spurious ack from another slave -> no error, data taken only from the selected slave.
- Assert rst_n low during ACCESS -> slv_req and all outputs 0 immediately; after release, a new read completes normally and err_count=0.
